// File: rtl/mem_pkg.sv
// Shared state type and widths for the MEM-stage memory access controller.
package mem_pkg;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int TO_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } memState_e;
endpackage

// File: rtl/mem_rdbuf.sv
// Single-entry load buffer (word tag + data), only built with MEMCTRL_RDBUF_EN.
module mem_rdbuf
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-3:0] lookupWord,
    output logic              hit,
    output logic [DATA_W-1:0] hitData,
    input  logic              readFill,
    input  logic              storeAck,
    input  logic [ADDR_W-3:0] ackWord,
    input  logic [DATA_W-1:0] readData,
    input  logic [DATA_W-1:0] storeData,
    input  logic              invalidate
);
    logic              valid;
    logic [ADDR_W-3:0] tag;
    logic [DATA_W-1:0] data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (invalidate) begin
            valid <= 1'b0;
        end else if (readFill) begin
            valid <= 1'b1;
            tag   <= ackWord;
            data  <= readData;
        end else if (storeAck && valid && (tag == ackWord)) begin
            data  <= storeData;
        end
    end

    assign hit     = valid && (tag == lookupWord);
    assign hitData = data;
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store bus controller with ack timeout. Optional read buffer: MEMCTRL_RDBUF_EN.
// IDLE: accept access | WAIT: bus_req held, await ack or timeout | DONE: release stall one cycle
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memreadM,
    input  logic              memwriteM,
    input  logic [ADDR_W-1:0] aluoutM,
    input  logic [DATA_W-1:0] writedataM,
    output logic [DATA_W-1:0] readdataM,
    output logic              memstallM,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_err,
    output logic              misalignM
);
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    memState_e           state, nextState;
    logic                weReg, busErrReg;
    logic [ADDR_W-1:0]   addrReg;
    logic [DATA_W-1:0]   wdataReg, dataReg;
    logic [TO_CNT_W-1:0] toCnt;
    logic                access, aligned, loadOnly, expire, ackInWait;
    logic                bufHit;
    logic [DATA_W-1:0]   bufData;

    assign access    = memreadM | memwriteM;
    assign aligned   = (aluoutM[1:0] == 2'b00);
    assign loadOnly  = memreadM & ~memwriteM;
    assign ackInWait = (state == WAIT) & bus_ack;
    assign expire    = (state == WAIT) & ~bus_ack & (toCnt == TO_LAST);

`ifdef MEMCTRL_RDBUF_EN
    mem_rdbuf uRdbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookupWord (aluoutM[ADDR_W-1:2]),
        .hit        (bufHit),
        .hitData    (bufData),
        .readFill   (ackInWait & ~weReg),
        .storeAck   (ackInWait & weReg),
        .ackWord    (addrReg[ADDR_W-1:2]),
        .readData   (bus_rdata),
        .storeData  (wdataReg),
        .invalidate (expire)
    );
`else
    assign bufHit  = 1'b0;
    assign bufData = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        memstallM = 1'b0;
        bus_req   = 1'b0;
        misalignM = 1'b0;
        readdataM = dataReg;
        case (state)
            IDLE: begin
                if (access && !aligned) begin
                    // Gated so a misaligned request held through reset never pulses.
                    misalignM = rst_n;
                    readdataM = '0;
                end else if (loadOnly && bufHit) begin
                    readdataM = bufData;
                end else if (access) begin
                    memstallM = 1'b1;
                    nextState = WAIT;
                end
            end
            WAIT: begin
                bus_req   = 1'b1;
                memstallM = 1'b1;
                if (bus_ack || expire) nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weReg     <= 1'b0;
            addrReg   <= '0;
            wdataReg  <= '0;
            dataReg   <= '0;
            toCnt     <= '0;
            busErrReg <= 1'b0;
        end else begin
            busErrReg <= 1'b0;
            if (state == IDLE && nextState == WAIT) begin
                weReg    <= memwriteM;
                addrReg  <= aluoutM;
                wdataReg <= writedataM;
                toCnt    <= '0;
            end else if (state == WAIT) begin
                if (bus_ack) begin
                    if (!weReg) dataReg <= bus_rdata;
                end else if (expire) begin
                    busErrReg <= 1'b1;
                    dataReg   <= '0;
                end else begin
                    toCnt <= toCnt + TO_CNT_W'(1);
                end
            end
        end
    end

    assign bus_we    = bus_req & weReg;
    assign bus_addr  = addrReg;
    assign bus_wdata = wdataReg;
    assign bus_err   = busErrReg;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a queue of expected load results.
module tb_mem_access_ctrl;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memreadM, memwriteM;
    logic [31:0] aluoutM, writedataM, readdataM;
    logic        memstallM, bus_req, bus_we, bus_ack, bus_err, misalignM;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int errors = 0;
    int checks = 0;
    logic [31:0] expQ[$];

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .memreadM   (memreadM),
        .memwriteM  (memwriteM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .memstallM  (memstallM),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .bus_err    (bus_err),
        .misalignM  (misalignM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge. ackAt = WAIT cycle carrying bus_ack (0 = never ack).
    task automatic doAccess(input string tag, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int ackAt, input logic [31:0] rdata,
                            input int expStall, input int expErr,
                            input logic [31:0] expData, input logic expMis);
        int stallCnt = 0;
        int waitCyc  = 0;
        int errCnt   = 0;
        int cyc      = 0;
        logic finished = 1'b0;
        logic [31:0] expRd;
        memreadM = rd; memwriteM = wr; aluoutM = addr; writedataM = wdata;
        if (rd && !wr) expQ.push_back(expData);
        while (!finished && cyc < 40) begin
            @(negedge clk);
            if (memstallM) stallCnt++;
            if (bus_err) errCnt++;
            if (bus_req) begin
                waitCyc++;
                chk({tag, "/bus_we"}, 32'(bus_we), 32'(wr));
                chk({tag, "/bus_addr"}, bus_addr, addr);
                if (wr) chk({tag, "/bus_wdata"}, bus_wdata, wdata);
                if (waitCyc == ackAt) begin
                    bus_ack = 1'b1;
                    bus_rdata = rdata;
                end
            end
            if (!memstallM) begin
                finished = 1'b1;
                chk({tag, "/misalign"}, 32'(misalignM), 32'(expMis));
                if (expStall == 0) chk({tag, "/no_req"}, 32'(bus_req), 32'd0);
                if (rd && !wr) begin
                    expRd = expQ.pop_front();
                    chk({tag, "/rdata"}, readdataM, expRd);
                end
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
            bus_rdata = '0;
            cyc++;
        end
        if (!finished) chk({tag, "/completed"}, 32'd0, 32'd1);
        chk({tag, "/stall_cycles"}, 32'(stallCnt), 32'(expStall));
        chk({tag, "/err_pulses"}, 32'(errCnt), 32'(expErr));
        memreadM = 1'b0; memwriteM = 1'b0; aluoutM = '0; writedataM = '0;
        @(negedge clk);
        chk({tag, "/idle_req"}, 32'(bus_req), 32'd0);
        chk({tag, "/idle_err"}, 32'(bus_err), 32'd0);
        chk({tag, "/idle_stall"}, 32'(memstallM), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        memreadM = 1'b0; memwriteM = 1'b0; aluoutM = '0; writedataM = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        #12;
        chk("rst/bus_req", 32'(bus_req), 32'd0);
        chk("rst/bus_we", 32'(bus_we), 32'd0);
        chk("rst/bus_err", 32'(bus_err), 32'd0);
        chk("rst/misalign", 32'(misalignM), 32'd0);
        chk("rst/stall", 32'(memstallM), 32'd0);
        chk("rst/rdata", readdataM, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        doAccess("load100", 1, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 4, 0, 32'hDEADBEEF, 0);
        chk("load100/hold", readdataM, 32'hDEADBEEF);
        doAccess("store200", 0, 1, 32'h200, 32'h12345678, 2, 32'h0, 3, 0, 32'h0, 0);
        doAccess("minlat", 1, 0, 32'h104, 32'h0, 1, 32'hCAFEF00D, 2, 0, 32'hCAFEF00D, 0);
        doAccess("timeout", 1, 0, 32'h108, 32'h0, 0, 32'h0, 1 + TO, 1, 32'h0, 0);
        doAccess("ackwins", 1, 0, 32'h10C, 32'h0, TO, 32'h0BADC0DE, 1 + TO, 0, 32'h0BADC0DE, 0);
        doAccess("misalign", 1, 0, 32'h103, 32'h0, 0, 32'h0, 0, 0, 32'h0, 1);
        doAccess("bothhigh", 1, 1, 32'h300, 32'hA5A5A5A5, 1, 32'h0, 2, 0, 32'h0, 0);

        // Stray ack while idle must not start anything or disturb the latched load data.
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_rdata = '0;
        @(negedge clk);
        chk("strayack/req", 32'(bus_req), 32'd0);
        chk("strayack/stall", 32'(memstallM), 32'd0);
        chk("strayack/rdata", readdataM, 32'h0BADC0DE);
        @(posedge clk); #1;

        doAccess("buf/fill", 1, 0, 32'h100, 32'h0, 2, 32'h11111111, 3, 0, 32'h11111111, 0);
`ifdef MEMCTRL_RDBUF_EN
        doAccess("buf/hit", 1, 0, 32'h100, 32'h0, 1, 32'h99999999, 0, 0, 32'h11111111, 0);
        doAccess("buf/store", 0, 1, 32'h100, 32'h55555555, 1, 32'h0, 2, 0, 32'h0, 0);
        doAccess("buf/hitnew", 1, 0, 32'h100, 32'h0, 1, 32'h99999999, 0, 0, 32'h55555555, 0);
`else
        doAccess("nobuf/reload", 1, 0, 32'h100, 32'h0, 1, 32'h22222222, 2, 0, 32'h22222222, 0);
        doAccess("nobuf/store", 0, 1, 32'h100, 32'h55555555, 1, 32'h0, 2, 0, 32'h0, 0);
        doAccess("nobuf/load", 1, 0, 32'h100, 32'h0, 1, 32'h55555555, 2, 0, 32'h55555555, 0);
`endif

        // Reset in the second WAIT cycle abandons the transaction.
        memreadM = 1'b1; aluoutM = 32'h400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstwait/req_before", 32'(bus_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstwait/req_async", 32'(bus_req), 32'd0);
        chk("rstwait/we_async", 32'(bus_we), 32'd0);
        chk("rstwait/rdata", readdataM, 32'd0);
        memreadM = 1'b0; aluoutM = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstwait/req_after", 32'(bus_req), 32'd0);
            chk("rstwait/stall_after", 32'(memstallM), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
